// File: rtl/onion_pwm_fade_pkg.sv
// Shared constants and types for the PWM fade scheduler.
package onion_pwm_fade_pkg;

    // Word addresses (byte offset >> 2)
    localparam logic [7:0] ADR_CTRL        = 8'h00;
    localparam logic [7:0] ADR_PRESCALE    = 8'h01;
    localparam logic [7:0] ADR_STATUS      = 8'h02;
    localparam logic [7:0] ADR_TARGET_BASE = 8'h10;
    localparam logic [7:0] ADR_CUR_BASE    = 8'h20;

    // STATUS bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_NAT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_PUSH = 2'd2
    } fade_state_e;

    // Expand 4 byte strobes into a 32-bit bit mask
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/onion_pwm_tick_gen.sv
// Prescaler: counts 0..prescale while enabled, single-cycle tick at terminal count.
module onion_pwm_tick_gen
    import onion_pwm_fade_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    // >= so a prescale lowered below the running count still terminates
    assign tick = en && (cnt >= prescale);

    // Counter is held at zero while disabled and restarts after each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (!en || tick) cnt <= '0;
        else                 cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/onion_pwm_fade_sched.sv
// Wishbone-slave scheduler stepping NUM_CH PWM duties toward their targets once per tick.
module onion_pwm_fade_sched
    import onion_pwm_fade_pkg::*;
#(
    parameter int          NUM_CH             = 8,
    parameter int          DUTY_W             = 8,
    parameter int          PRESCALE_W         = 16,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic              WBs_CLK_i,
    input  logic              WBs_RST_i,
    input  logic [7:0]        WBs_ADR_i,
    input  logic              WBs_CYC_i,
    input  logic [3:0]        WBs_BYTE_STB_i,
    input  logic              WBs_WE_i,
    input  logic              WBs_STB_i,
    input  logic [31:0]       WBs_DAT_i,
    output logic [31:0]       WBs_DAT_o,
    output logic              WBs_ACK_o,
    output logic              PWM_WE_o,
    output logic [4:0]        PWM_CH_o,
    output logic [DUTY_W-1:0] PWM_DUTY_o,
    input  logic              PWM_RDY_i,
    output logic              BUSY_o
);

    localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);
    localparam logic [7:0]       NUM_CH_B = 8'(NUM_CH);

    logic                               en, overrun, tick, tick_pending;
    logic [PRESCALE_W-1:0]              prescale;
    logic [NUM_CH-1:0][DUTY_W-1:0]      tgt, step, cur;
    fade_state_e                        state, state_nx;
    logic [IDX_W-1:0]                   ch, ch_nx;
    logic                               load, accept, pend_clr;
    logic [DUTY_W-1:0]                  next_duty;

    // ---------------- bus decode ----------------
    logic              req, wr, is_tgt, is_cur;
    logic [7:0]        tgt_off, cur_off;
    logic [IDX_W-1:0]  ti, ci;
    logic [31:0]       m, tword, tgt_mrg, pre_mrg, status;

    assign req     = WBs_CYC_i & WBs_STB_i;
    assign wr      = req & WBs_ACK_o & WBs_WE_i;
    assign tgt_off = WBs_ADR_i - ADR_TARGET_BASE;
    assign cur_off = WBs_ADR_i - ADR_CUR_BASE;
    assign is_tgt  = (WBs_ADR_i >= ADR_TARGET_BASE) && (tgt_off < NUM_CH_B);
    assign is_cur  = (WBs_ADR_i >= ADR_CUR_BASE) && (cur_off < NUM_CH_B);
    assign ti      = tgt_off[IDX_W-1:0];
    assign ci      = cur_off[IDX_W-1:0];
    assign m       = be_mask(WBs_BYTE_STB_i);

    // Register images used by both the read mux and byte-merged writes
    always_comb begin
        tword = '0;
        tword[DUTY_W-1:0] = tgt[ti];
        tword[DUTY_W+7:8] = step[ti];
        tgt_mrg = (tword & ~m) | (WBs_DAT_i & m);
        pre_mrg = (32'(prescale) & ~m) | (WBs_DAT_i & m);
        status = '0;
        status[ST_BUSY]    = BUSY_o;
        status[ST_OVERRUN] = overrun;
        for (int n = 0; n < NUM_CH; n++)
            if (ST_NAT_LSB + n < 32) status[ST_NAT_LSB + n] = (cur[n] != tgt[n]);
    end

    logic unused_bits;
    assign unused_bits = ^{tgt_mrg, pre_mrg};

    // Zero-wait read mux
    always_comb begin
        WBs_DAT_o = DEFAULT_READ_VALUE;
        if (is_tgt) WBs_DAT_o = tword;
        else if (is_cur) begin
            WBs_DAT_o = '0;
            WBs_DAT_o[DUTY_W-1:0] = cur[ci];
        end else begin
            case (WBs_ADR_i)
                ADR_CTRL:     WBs_DAT_o = {31'b0, en};
                ADR_PRESCALE: WBs_DAT_o = 32'(prescale);
                ADR_STATUS:   WBs_DAT_o = status;
                default:      ;
            endcase
        end
    end

    // Single-cycle registered acknowledge
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) WBs_ACK_o <= 1'b0;
        else            WBs_ACK_o <= req & ~WBs_ACK_o;
    end

    // Software-visible registers; a dropped tick beats a same-cycle W1C
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            en       <= 1'b0;
            prescale <= '0;
            overrun  <= 1'b0;
            tgt      <= '0;
            step     <= '0;
        end else begin
            if (wr) begin
                if (is_tgt) begin
                    tgt[ti]  <= tgt_mrg[DUTY_W-1:0];
                    step[ti] <= tgt_mrg[DUTY_W+7:8];
                end else if (WBs_ADR_i == ADR_CTRL && WBs_BYTE_STB_i[0])
                    en <= WBs_DAT_i[0];
                else if (WBs_ADR_i == ADR_PRESCALE)
                    prescale <= pre_mrg[PRESCALE_W-1:0];
                else if (WBs_ADR_i == ADR_STATUS && WBs_BYTE_STB_i[0] && WBs_DAT_i[ST_OVERRUN])
                    overrun <= 1'b0;
            end
            if (tick && tick_pending && !pend_clr) overrun <= 1'b1;
        end
    end

    onion_pwm_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .clk      (WBs_CLK_i),
        .rst_n    (WBs_RST_i),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // ---------------- step arithmetic ----------------
    logic [DUTY_W-1:0] cur_c, tgt_c, stp_c;
    logic [DUTY_W:0]   d_up, d_dn;
    assign cur_c = cur[ch];
    assign tgt_c = tgt[ch];
    assign stp_c = step[ch];
    assign d_up  = {1'b0, tgt_c} - {1'b0, cur_c};
    assign d_dn  = {1'b0, cur_c} - {1'b0, tgt_c};

    // One step toward target; step 0 or a remaining gap within step lands exactly on target
    always_comb begin
        next_duty = cur_c;
        if (tgt_c > cur_c)
            next_duty = (stp_c == '0 || d_up <= {1'b0, stp_c}) ? tgt_c : cur_c + stp_c;
        else if (tgt_c < cur_c)
            next_duty = (stp_c == '0 || d_dn <= {1'b0, stp_c}) ? tgt_c : cur_c - stp_c;
    end

    // ---------------- scan FSM ----------------
    // State register
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            state <= S_IDLE;
            ch    <= '0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        case (state)
            S_IDLE: if (pend_clr) begin
                ch_nx    = '0;
                state_nx = S_EVAL;
            end
            S_EVAL: begin
                if (!en)                 state_nx = S_IDLE;
                else if (load)           state_nx = S_PUSH;
                else if (ch == LAST_CH)  state_nx = S_IDLE;
                else                     ch_nx    = ch + 1'b1;
            end
            S_PUSH: if (accept) begin
                if (ch == LAST_CH || !en) state_nx = S_IDLE;
                else begin
                    ch_nx    = ch + 1'b1;
                    state_nx = S_EVAL;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output/control decode
    always_comb begin
        pend_clr = (state == S_IDLE) && tick_pending && en;
        load     = (state == S_EVAL) && en && (next_duty != cur_c);
        accept   = (state == S_PUSH) && PWM_RDY_i;
    end

    assign BUSY_o = (state != S_IDLE);

    // Duty-write port, committed duties and the pending-tick flag
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            PWM_WE_o     <= 1'b0;
            PWM_CH_o     <= '0;
            PWM_DUTY_o   <= '0;
            cur          <= '0;
            tick_pending <= 1'b0;
        end else begin
            if (load) begin
                PWM_WE_o   <= 1'b1;
                PWM_CH_o   <= 5'(ch);
                PWM_DUTY_o <= next_duty;
            end else if (accept) begin
                PWM_WE_o <= 1'b0;
                cur[ch]  <= PWM_DUTY_o;
            end
            if (!en)           tick_pending <= 1'b0;
            else if (tick)     tick_pending <= 1'b1;
            else if (pend_clr) tick_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onion_pwm_fade_sched.sv
// Directed bench for onion_pwm_fade_sched.
module tb_onion_pwm_fade_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  adr;
    logic        cyc, we, stb, rdy;
    logic [3:0]  be;
    logic [31:0] dat_w, dat_r;
    logic        ack, pwm_we, busy;
    logic [4:0]  pwm_ch;
    logic [7:0]  pwm_duty;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] q_ch[$];
    logic [7:0] q_duty[$];

    always #5 clk = ~clk;

    onion_pwm_fade_sched dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
        .WBs_BYTE_STB_i(be), .WBs_WE_i(we), .WBs_STB_i(stb), .WBs_DAT_i(dat_w),
        .WBs_DAT_o(dat_r), .WBs_ACK_o(ack), .PWM_WE_o(pwm_we), .PWM_CH_o(pwm_ch),
        .PWM_DUTY_o(pwm_duty), .PWM_RDY_i(rdy), .BUSY_o(busy)
    );

    // Record every accepted duty write
    always @(posedge clk)
        if (rst_n && pwm_we && rdy) begin
            q_ch.push_back(pwm_ch);
            q_duty.push_back(pwm_duty);
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        adr = a; dat_w = d; be = b; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d,
                           output logic a1, output logic a2);
        adr = a; we = 1'b0; be = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        a1 = ack; d = dat_r;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        a2 = ack;
    endtask

    task automatic wait_we(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (pwm_we) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic a1, a2;
        rst_n = 1'b0; adr = 8'h00; cyc = 0; we = 0; stb = 0; be = 4'h0;
        dat_w = '0; rdy = 1'b0;
        #1;
        chk("rst_pwm_we", 32'(pwm_we), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dat_ctrl", dat_r, 0);
        #23 rst_n = 1'b1;
        cycles(2);
        wb_read(8'h02, d, a1, a2);
        chk("rst_status", d, 0);

        // Ramp up ch0 to 200 in steps of 50
        wb_write(8'h01, 32'd3, 4'hF);
        wb_write(8'h10, 32'h32C8, 4'hF);
        rdy = 1'b1;
        q_ch.delete(); q_duty.delete();
        wb_write(8'h00, 32'd1, 4'hF);
        cycles(150);
        chk("ramp_count", 32'(q_duty.size()), 4);
        chk("ramp_ch", 32'(q_ch[0]), 0);
        chk("ramp_w0", 32'(q_duty[0]), 50);
        chk("ramp_w1", 32'(q_duty[1]), 100);
        chk("ramp_w2", 32'(q_duty[2]), 150);
        chk("ramp_w3", 32'(q_duty[3]), 200);
        wb_read(8'h20, d, a1, a2);
        chk("ramp_cur0", d, 200);
        wb_read(8'h02, d, a1, a2);
        chk("ramp_nat0", 32'(d[8]), 0);

        // Saturating ramp down on ch2: jump to 200, then 200 -> 100 -> 30
        wb_write(8'h12, 32'h00C8, 4'hF);
        cycles(60);
        wb_write(8'h00, 32'd0, 4'hF);
        cycles(20);
        wb_read(8'h22, d, a1, a2);
        chk("down_cur2_start", d, 200);
        wb_write(8'h12, 32'h641E, 4'hF);
        wb_read(8'h02, d, a1, a2);
        chk("down_nat2_set", 32'(d[10]), 1);
        q_ch.delete(); q_duty.delete();
        wb_write(8'h00, 32'd1, 4'hF);
        cycles(100);
        wb_write(8'h00, 32'd0, 4'hF);
        cycles(20);
        chk("down_count", 32'(q_duty.size()), 2);
        chk("down_ch", 32'(q_ch[0]), 2);
        chk("down_w0", 32'(q_duty[0]), 100);
        chk("down_w1", 32'(q_duty[1]), 30);
        wb_read(8'h02, d, a1, a2);
        chk("down_nat2_clr", 32'(d[10]), 0);

        // Backpressure on ch3
        rdy = 1'b0;
        q_ch.delete(); q_duty.delete();
        wb_write(8'h13, 32'h004D, 4'hF);
        wb_write(8'h00, 32'd1, 4'hF);
        wait_we("bp_we_seen");
        for (int i = 0; i < 5; i++) begin
            chk("bp_we_hold", 32'(pwm_we), 1);
            chk("bp_ch_hold", 32'(pwm_ch), 3);
            chk("bp_duty_hold", 32'(pwm_duty), 8'h4D);
            cycles(1);
        end
        rdy = 1'b1;
        cycles(1);
        chk("bp_we_drop", 32'(pwm_we), 0);
        chk("bp_count", 32'(q_duty.size()), 1);
        chk("bp_duty", 32'(q_duty[0]), 8'h4D);
        wb_write(8'h00, 32'd0, 4'hF);
        cycles(20);
        chk("bp_count_final", 32'(q_duty.size()), 1);
        wb_read(8'h23, d, a1, a2);
        chk("bp_cur3", d, 8'h4D);

        // Overrun with PRESCALE=0 and the PWM side stalled
        rdy = 1'b0;
        wb_write(8'h14, 32'd10, 4'hF);
        wb_write(8'h15, 32'd20, 4'hF);
        wb_write(8'h01, 32'd0, 4'hF);
        wb_write(8'h02, 32'h2, 4'hF);
        wb_read(8'h02, d, a1, a2);
        chk("ovr_clear_before", 32'(d[1]), 0);
        wb_write(8'h00, 32'd1, 4'hF);
        cycles(10);
        wb_read(8'h02, d, a1, a2);
        chk("ovr_set", 32'(d[1]), 1);
        chk("ovr_busy", 32'(busy), 1);
        wb_write(8'h00, 32'd0, 4'hF);
        wb_write(8'h02, 32'h2, 4'hF);
        wb_read(8'h02, d, a1, a2);
        chk("ovr_w1c", 32'(d[1]), 0);
        rdy = 1'b1;
        cycles(5);
        chk("ovr_idle", 32'(busy), 0);
        wb_read(8'h24, d, a1, a2);
        chk("en_off_cur4", d, 10);
        wb_read(8'h25, d, a1, a2);
        chk("en_off_cur5_skipped", d, 0);

        // Bus: unmapped read, byte-lane write
        wb_read(8'h0F, d, a1, a2);
        chk("bus_default", d, 32'hBADFABAC);
        chk("bus_ack_hi", 32'(a1), 1);
        chk("bus_ack_lo", 32'(a2), 0);
        wb_write(8'h11, 32'h1234, 4'hF);
        wb_read(8'h11, d, a1, a2);
        chk("bus_tgt1_full", d, 32'h1234);
        wb_write(8'h11, 32'h56AB, 4'b0001);
        wb_read(8'h11, d, a1, a2);
        chk("bus_tgt1_byte", d, 32'h12AB);
        wb_read(8'h01, d, a1, a2);
        chk("bus_prescale", d, 0);

        // Asynchronous reset while a push is stalled (ch1: 0 -> 0x12)
        rdy = 1'b0;
        wb_write(8'h01, 32'd3, 4'hF);
        wb_write(8'h00, 32'd1, 4'hF);
        wait_we("rst_we_seen");
        chk("rst_push_ch", 32'(pwm_ch), 1);
        chk("rst_push_duty", 32'(pwm_duty), 8'h12);
        adr = 8'h20;
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", 32'(pwm_we), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_cur0", dat_r, 0);
        adr = 8'h23;
        #1;
        chk("async_cur3", dat_r, 0);
        #20 rst_n = 1'b1;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
